// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control inputs, instruction memory port and the IF/ID register outputs.
// The fetch unit uses the slave view; the pipeline/memory environment uses the master view.
interface instruction_fetch_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] if_id_instr;
    logic [ADDR_W-1:0] if_id_pc;
    logic              if_id_valid;
    logic              halted;
    logic [15:0]       fetch_count;

    modport slave (
        input  stall, branch_taken, branch_target, imem_data,
        output imem_addr, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count
    );

    modport master (
        output stall, branch_taken, branch_target, imem_data,
        input  imem_addr, if_id_instr, if_id_pc, if_id_valid, halted, fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALTED fetch FSM.
// Priority each cycle is branch redirect, then stall, then normal fetch.
module instruction_fetch #(
    parameter int                 ADDR_W    = 15,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    instruction_fetch_if.slave bus
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              valid_q, valid_d;
    logic [15:0]       count_q, count_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        count_d = count_q;

        if (bus.branch_taken) begin
            state_d = RUN;
            pc_d    = bus.branch_target;
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            unique case (state_q)
                RUN: begin
                    instr_d = bus.imem_data;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                    // A halt word is delivered, then the PC parks on its address.
                    if (bus.imem_data == HALT_WORD) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
                HALTED: begin
                    instr_d = '0;
                    valid_d = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc    = ipc_q;
    assign bus.if_id_valid = valid_q;
    assign bus.halted      = (state_q == HALTED);
    assign bus.fetch_count = count_q;

endmodule
